imem_boot_ctrl: RTL and testbench

- Boot/load controller for the single-port-write, async-read instruction RAM.
- Assembles a byte stream (from a UART receiver or debug host) into 32-bit little-endian words and writes them into consecutive IMEM words.
- Holds the core in reset while loading, then releases it to run.
- During RUN, muxes the core's fetch address onto the RAM read port; while not running, returns NOP to fetch.

---
 rtl/imem_boot_ctrl_if.sv | 11 +
 rtl/imem_boot_ctrl.sv | 121 ++++++++++++
 tb/tb_imem_boot_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream load channel between a host (UART receiver / debug port) and imem_boot_ctrl.
interface imem_boot_ctrl_if;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_byte;
  logic       ld_ready;
  logic       ld_done;

  modport master (output ld_start, ld_valid, ld_byte, ld_done, input ld_ready);
  modport slave  (input ld_start, ld_valid, ld_byte, ld_done, output ld_ready);
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-RAM boot controller: packs a little-endian byte stream into IMEM words, then releases the core.
// Optional macro IMEM_BOOT_CHECKSUM_EN adds a wrapping 32-bit sum of all written words.
module imem_boot_ctrl #(
  parameter int          DEPTH    = 64,
  parameter int          AW       = 6,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  imem_boot_ctrl_if.slave   ld,
  output logic              core_rst,
  output logic [AW:0]       words_loaded,
  output logic              overflow,
  input  logic [31:0]       fetch_a,
  output logic [31:0]       fetch_rd,
  output logic              fetch_misalign,
  output logic              mem_we,
  output logic [AW-1:0]     mem_wa,
  output logic [31:0]       mem_wd,
  output logic [AW-1:0]     mem_ra,
  input  logic [31:0]       mem_rd
`ifdef IMEM_BOOT_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {LOAD, FLUSH, RUN} state_t;

  state_t        state, state_nxt;
  logic [1:0]    byte_idx, idx_nxt;
  logic [AW-1:0] wptr;
  logic [31:0]   asm_word, asm_nxt;
  logic          ready, full, accept, last_byte, pad, wr_fire;
  logic          unused_fetch_hi;

  assign unused_fetch_hi = ^fetch_a[31:AW+2];

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    full      = (words_loaded == FULL_CNT);
    ready     = (state == LOAD) && !full;
    accept    = ld.ld_valid && ready && !ld.ld_start;
    last_byte = accept && (byte_idx == 2'd3);
    idx_nxt   = accept ? byte_idx + 2'd1 : byte_idx;
    asm_nxt   = asm_word;
    if (accept) asm_nxt[{byte_idx, 3'b000} +: 8] = ld.ld_byte;
    // A trailing partial word is written immediately, so its pulse lands in the FLUSH cycle
    pad       = (state == LOAD) && ld.ld_done && !ld.ld_start && !last_byte && (idx_nxt != 2'd0);
    wr_fire   = last_byte || pad;
    case (state)
      LOAD:    if (ld.ld_done) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = LOAD;
    endcase
    if (ld.ld_start) state_nxt = LOAD;
  end

  assign ld.ld_ready = ready;

  // stage p0 -> p1: byte assembly and registered RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx     <= 2'd0;
      wptr         <= '0;
      asm_word     <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
      mem_we       <= 1'b0;
      mem_wa       <= '0;
      mem_wd       <= '0;
      core_rst     <= 1'b1;
    end else begin
      mem_we   <= 1'b0;
      core_rst <= (state != RUN);
      if (ld.ld_start) begin
        byte_idx     <= 2'd0;
        wptr         <= '0;
        asm_word     <= '0;
        words_loaded <= '0;
        overflow     <= 1'b0;
      end else begin
        if ((state == LOAD) && ld.ld_valid && full) overflow <= 1'b1;
        if (wr_fire) begin
          mem_we       <= 1'b1;
          mem_wa       <= wptr;
          mem_wd       <= asm_nxt;
          wptr         <= wptr + PTR_ONE;
          words_loaded <= words_loaded + CNT_ONE;
          asm_word     <= '0;
          byte_idx     <= 2'd0;
        end else if (accept) begin
          asm_word <= asm_nxt;
          byte_idx <= idx_nxt;
        end
      end
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || ld.ld_start) checksum <= '0;
    else if (wr_fire)         checksum <= checksum + asm_nxt;
  end
`endif

  assign mem_ra         = fetch_a[AW+1:2];
  assign fetch_rd       = (state == RUN) ? mem_rd : NOP_INSN;
  assign fetch_misalign = (state == RUN) && (fetch_a[1:0] != 2'b00);

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized scoreboard bench for imem_boot_ctrl with a queue-based loader model and a behavioural RAM.
module tb_imem_boot_ctrl;
  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    logic [31:0] sum;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  imem_boot_ctrl_if ifc ();
  logic          core_rst, overflow, fetch_misalign, mem_we;
  logic [AW:0]   words_loaded;
  logic [31:0]   fetch_a, fetch_rd, mem_wd, mem_rd;
  logic [AW-1:0] mem_wa, mem_ra;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0]   checksum;
`endif
  logic [31:0]   ram [DEPTH] = '{default: 32'h0};

  // reference model state
  bit          loading;
  int          wcount;
  bit          ovf;
  logic [31:0] csum;
  logic [7:0]  part [$];
  logic [31:0] img [DEPTH] = '{default: 32'h0};
  wr_t         exp_q [$];
  int          n_pass = 0;
  int          n_checks = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW), .NOP_INSN(NOP)) dut (
    .clk(clk), .reset(reset), .ld(ifc), .core_rst(core_rst),
    .words_loaded(words_loaded), .overflow(overflow),
    .fetch_a(fetch_a), .fetch_rd(fetch_rd), .fetch_misalign(fetch_misalign),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .mem_ra(mem_ra), .mem_rd(mem_rd)
`ifdef IMEM_BOOT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always @(posedge clk) if (mem_we === 1'b1) ram[mem_wa] <= mem_wd;
  assign mem_rd = ram[mem_ra];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void emit();
    wr_t e;
    logic [31:0] w;
    w = 32'h0;
    foreach (part[k]) w |= 32'(part[k]) << (8 * k);
    img[wcount] = w;
    csum += w;
    e.addr = wcount;
    e.data = w;
    e.sum  = csum;
    exp_q.push_back(e);
    wcount++;
    part.delete();
  endfunction

  // One clock of stimulus, issued at a falling edge; model advances with it.
  task automatic step(input bit v, input logic [7:0] b, input bit s = 0, input bit d = 0, input bit r = 0);
    chk("ld_ready", {31'b0, ifc.ld_ready}, {31'b0, loading && (wcount < DEPTH)});
    reset = r; ifc.ld_valid = v; ifc.ld_byte = b; ifc.ld_start = s; ifc.ld_done = d;
    if (r || s) begin
      loading = 1; part.delete(); wcount = 0; ovf = 0; csum = 0;
    end else if (loading) begin
      if (v) begin
        if (wcount < DEPTH) begin
          part.push_back(b);
          if (part.size() == 4) emit();
        end else ovf = 1;
      end
      if (d) begin
        if (part.size() != 0) emit();
        loading = 0;
      end
    end
    @(negedge clk);
    reset = 0; ifc.ld_valid = 0; ifc.ld_start = 0; ifc.ld_done = 0;
  endtask

  // Called at the falling edge right after ld_done was taken (FLUSH cycle).
  task automatic enter_run();
    fetch_a = 32'h4; #1;
    chk("core_rst_flush", {31'b0, core_rst}, 32'h1);
    chk("fetch_rd_flush", fetch_rd, NOP);
    @(negedge clk); #1;
    chk("core_rst_run0", {31'b0, core_rst}, 32'h1);
    chk("fetch_rd_run0", fetch_rd, img[1]);
    @(negedge clk); #1;
    chk("core_rst_run1", {31'b0, core_rst}, 32'h0);
  endtask

  task automatic check_run();
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      a = ($urandom() & ~32'(DEPTH * 4 - 1)) | 32'(i * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      fetch_a = a; #1;
      chk("fetch_rd", fetch_rd, img[i]);
      chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, a[1:0] != 2'b00});
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest predicted write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", mem_wa, mem_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_wa), e.addr);
        chk("write_data", mem_wd, e.data);
        chk("words_loaded_at_write", 32'(words_loaded), e.addr + 1);
`ifdef IMEM_BOOT_CHECKSUM_EN
        chk("checksum_at_write", checksum, e.sum);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nb, sent;
    bit  dd;
    reset = 1; fetch_a = 32'h0;
    ifc.ld_valid = 0; ifc.ld_byte = 0; ifc.ld_start = 0; ifc.ld_done = 0;
    loading = 1; wcount = 0; ovf = 0; csum = 0;
    repeat (2) @(negedge clk);
    fetch_a = $urandom(); #1;
    chk("rst_core_rst", {31'b0, core_rst}, 32'h1);
    chk("rst_words_loaded", 32'(words_loaded), 32'h0);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_fetch_rd", fetch_rd, NOP);
    reset = 0;
    @(negedge clk);

    // first word, then second word and release
    step(1, 8'h13); step(1, 8'h08); step(1, 8'h80); step(1, 8'h02);
    chk("t1_words_loaded", 32'(words_loaded), 32'h1);
    chk("t1_core_rst", {31'b0, core_rst}, 32'h1);
    chk("t1_fetch_rd", fetch_rd, NOP);
    step(1, 8'h93); step(1, 8'h08); step(1, 8'h40); step(1, 8'hFF);
    step(0, 8'h0, 0, 1);
    enter_run();
    fetch_a = 32'h4; #1;
    chk("t2_fetch_w1", fetch_rd, 32'hFF400893);
    step(0, 8'h0, 0, 1);
    #1 chk("t2_done_ignored_core_rst", {31'b0, core_rst}, 32'h0);

    // 5 bytes with padded tail word
    step(0, 8'h0, 1);
    step(1, 8'h37); step(1, 8'hA4); step(1, 8'h03); step(1, 8'h00); step(1, 8'h93);
    step(0, 8'h0, 0, 1);
    enter_run();
    chk("t3_words_loaded", 32'(words_loaded), 32'h2);
    chk("t3_pad_word", img[1], 32'h00000093);
`ifdef IMEM_BOOT_CHECKSUM_EN
    chk("t3_checksum", checksum, 32'h0003A4CA);
`endif
    check_run();

    // ld_start + ld_done mid-word: partial discarded, stays in LOAD
    step(0, 8'h0, 1);
    step(1, 8'hAA); step(1, 8'hBB); step(1, 8'hCC, 1, 1);
    step(0, 8'h0); step(0, 8'h0);
    chk("t5_words_loaded", 32'(words_loaded), 32'h0);
    chk("t5_core_rst", {31'b0, core_rst}, 32'h1);
    for (int k = 0; k < 4; k++) step(1, 8'($urandom()));
    step(0, 8'h0, 0, 1);
    enter_run();
    check_run();

    // misaligned fetch, then reset while running
    @(negedge clk);
    fetch_a = 32'h6; #1;
    chk("t6_misalign", {31'b0, fetch_misalign}, 32'h1);
    chk("t6_misalign_rd", fetch_rd, img[1]);
    @(negedge clk);
    step(0, 8'h0, 0, 0, 1);
    #1;
    chk("t6_core_rst", {31'b0, core_rst}, 32'h1);
    chk("t6_fetch_nop", fetch_rd, NOP);
    chk("t6_misalign_off", {31'b0, fetch_misalign}, 32'h0);
    chk("t6_ram0_kept", ram[0], img[0]);

    // reset on the 4th-byte handshake cancels that write
    step(1, 8'h11); step(1, 8'h22); step(1, 8'h33); step(1, 8'h44, 0, 0, 1);
    step(0, 8'h0);
    chk("t6_cancel_words_loaded", 32'(words_loaded), 32'h0);
    chk("t6_cancel_mem_we", {31'b0, mem_we}, 32'h0);

    // overflow: 4*DEPTH+2 bytes
    step(0, 8'h0, 1);
    for (int k = 0; k < 4 * DEPTH + 2; k++) step(1, 8'($urandom()));
    chk("t4_words_loaded", 32'(words_loaded), 32'(DEPTH));
    chk("t4_overflow", {31'b0, overflow}, {31'b0, ovf});
    step(0, 8'h0, 0, 1);
    enter_run();
    check_run();
    step(0, 8'h0, 1);
    chk("t4_overflow_cleared", {31'b0, overflow}, 32'h0);

    // randomized loads with gaps and optional same-cycle ld_done
    repeat (4) begin
      nb = $urandom_range(1, 70);
      sent = 0;
      step(0, 8'h0, 1);
      while (sent < nb) begin
        if ($urandom_range(0, 3) == 0) step(0, 8'($urandom()));
        else begin
          sent++;
          dd = (sent == nb) && ($urandom_range(0, 1) == 1);
          step(1, 8'($urandom()), 0, dd);
          if (sent == nb && !dd) step(0, 8'h0, 0, 1);
        end
      end
      enter_run();
      chk("rnd_words_loaded", 32'(words_loaded), 32'(wcount));
`ifdef IMEM_BOOT_CHECKSUM_EN
      chk("rnd_checksum", checksum, csum);
`endif
      check_run();
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    chk("write_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
